// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front end of the single-cycle core. Owns the PC, runs a req/ready +
//   rvalid handshake with instruction memory, buffers one instruction and
//   presents it to the control path pre-split into its fields. The branch
//   decision (PCSrc, pc_target) is taken only when the buffered instruction
//   is consumed.
//
// Ports
//   clk, rst                 core clock (rising edge), synchronous active-low reset
//   imem_req/imem_addr       fetch request and word-aligned byte address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid/imem_rdata   read response
//   instr_valid/instr_ready  buffered-instruction handshake with the core
//   instr, Op, funct3, funct7, rd, rs1, rs2   instruction word and its fields
//   pc_out                   PC of the buffered instruction
//   PCSrc, pc_target         next-PC select (1 = target, 0 = PC+4)
//   retire_cnt               consumed-instruction count (FETCH_RETIRE_CNT_EN only)
//
// Build option
//   FETCH_RETIRE_CNT_EN  adds the retire_cnt output and its counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | request instruction at PC, wait for imem_ready
// WAIT     | request accepted, wait for imem_rvalid, then buffer it
// ISSUE    | buffered instruction offered to the core until consumed

module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [6:0]        Op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [ADDR_W-1:0] pc_out,
`ifdef FETCH_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] pc_target
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_out_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              req_q;

  // Misaligned targets are silently aligned; PC+4 wraps naturally.
  always_comb begin
    pc_d = pc_q + ADDR_W'(4);
    if (PCSrc) begin
      pc_d = pc_target & ~ADDR_W'(3);
    end
  end

  // req_q is registered, so it comes up one cycle after reset release;
  // imem_ready is only honoured once the request is actually visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ready) begin
            req_q   <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_q  <= imem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_q <= '0;
    end else if (valid_q && instr_ready) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign instr       = instr_q;
  assign Op          = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign funct3      = instr_q[14:12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign funct7      = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc_out;
  logic        PCSrc;
  logic [31:0] pc_target;
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_pc;
  int exp_retire;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .Op         (Op),
    .funct3     (funct3),
    .funct7     (funct7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .pc_out     (pc_out),
`ifdef FETCH_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .PCSrc      (PCSrc),
    .pc_target  (pc_target)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    pc_target   = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom; instr_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr); end
    checks++; if (Op !== 7'h13 || rd !== 5'd0 || funct3 !== 3'd0) begin errors++; $display("FAIL rst_fields got op %h rd %0d f3 %0d exp 13 0 0", Op, rd, funct3); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got %h exp 0", pc_out); end
`ifdef FETCH_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_retire got %0d exp 0", retire_cnt); end
`endif
    idle_inputs();
    rst = 1'b1;
    exp_pc = 32'h0;
    exp_retire = 0;
  endtask

  // First fetch, sequential 0,4,8, then branch at pc_out=8 to 0x42 -> 0x40.
  task automatic test_seq_branch();
    logic [31:0] addrs [4];
    logic [31:0] word;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'h40;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 8 && imem_req !== 1'b1; w++) tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req_timeout k %0d got %b exp 1", k, imem_req); end
      checks++; if (imem_addr !== addrs[k]) begin errors++; $display("FAIL seq_addr k %0d got %h exp %h", k, imem_addr, addrs[k]); end
      word = (k == 0) ? 32'h0050_0093 : $urandom;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = word;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait k %0d got valid %b req %b exp 0 0", k, instr_valid, imem_req); end
      tick();
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k %0d got %b exp 1", k, instr_valid); end
      checks++; if (instr !== word || pc_out !== addrs[k]) begin errors++; $display("FAIL seq_instr k %0d got %h @%h exp %h @%h", k, instr, pc_out, word, addrs[k]); end
      if (k == 0) begin
        checks++; if (Op !== 7'h13 || rd !== 5'd1 || funct3 !== 3'd0 || rs1 !== 5'd0 || rs2 !== 5'd5 || funct7 !== 7'd0) begin
          errors++; $display("FAIL seq_fields0 got op %h rd %0d f3 %0d rs1 %0d rs2 %0d f7 %0d exp 13 1 0 0 5 0", Op, rd, funct3, rs1, rs2, funct7);
        end
      end else begin
        checks++; if ({funct7, rs2, rs1, funct3, rd, Op} !== word) begin errors++; $display("FAIL seq_fields k %0d got %h exp %h", k, {funct7, rs2, rs1, funct3, rd, Op}, word); end
      end
      instr_ready = 1'b1;
      PCSrc = (k == 2);
      pc_target = (k == 2) ? 32'h0000_0042 : $urandom;
      tick();
      exp_retire++;
      instr_ready = 1'b0; PCSrc = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL seq_next k %0d got valid %b req %b exp 0 1", k, instr_valid, imem_req); end
    end
    exp_pc = 32'h44;
  endtask

  task automatic test_stall();
    logic [31:0] word;
    for (int w = 0; w < 8 && imem_req !== 1'b1; w++) tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stall_req got %b %h exp 1 %h", imem_req, imem_addr, exp_pc); end
    word = $urandom;
    imem_ready = 1'b1; tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = word; tick();
    imem_rvalid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold s %0d got valid %b req %b exp 1 0", s, instr_valid, imem_req); end
      checks++; if (instr !== word || pc_out !== exp_pc) begin errors++; $display("FAIL stall_data s %0d got %h @%h exp %h @%h", s, instr, pc_out, word, exp_pc); end
      instr_ready = 1'b0; PCSrc = 1'b1; pc_target = $urandom;
      tick();
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid6 got %b exp 1", instr_valid); end
    instr_ready = 1'b1; PCSrc = 1'b0;
    tick();
    instr_ready = 1'b0;
    exp_pc = exp_pc + 32'd4;
    exp_retire++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL stall_refetch got %b %h exp 1 %h", imem_req, imem_addr, exp_pc); end
`ifdef FETCH_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'(exp_retire)) begin errors++; $display("FAIL stall_retire got %0d exp %0d", retire_cnt, exp_retire); end
`endif
  endtask

  task automatic test_wrap_backpressure();
    logic [31:0] word;
    for (int w = 0; w < 8 && imem_req !== 1'b1; w++) tick();
    imem_ready = 1'b1; tick();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom; tick();
    imem_rvalid = 1'b0;
    instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'hFFFF_FFFE;
    tick();
    instr_ready = 1'b0; PCSrc = 1'b0;
    exp_retire++;
    for (int s = 0; s < 4; s++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hold s %0d got %b %h exp 1 fffffffc", s, imem_req, imem_addr); end
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = $urandom;
      tick();
    end
    imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom;
    tick();
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_same_cycle got %b exp 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_waiting got %b exp 0", instr_valid); end
    word = $urandom;
    imem_rvalid = 1'b1; imem_rdata = word; tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== word || pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_issue got %b %h @%h exp 1 %h @fffffffc", instr_valid, instr, pc_out, word); end
    instr_ready = 1'b1; PCSrc = 1'b0; tick();
    instr_ready = 1'b0;
    exp_retire++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %b %h exp 1 0", imem_req, imem_addr); end
    exp_pc = 32'h0;
  endtask

  task automatic test_mid_wait_reset();
    logic [31:0] word;
    for (int w = 0; w < 8 && imem_req !== 1'b1; w++) tick();
    imem_ready = 1'b1; tick();
    imem_ready = 1'b0; rst = 1'b0; tick();
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = $urandom; tick();
    imem_rvalid = 1'b0;
    exp_retire = 0;
`ifdef FETCH_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL mwr_retire0 got %0d exp 0", retire_cnt); end
`endif
    for (int s = 0; s < 3; s++) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mwr_dropped s %0d got %b exp 0", s, instr_valid); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8 && imem_req !== 1'b1; w++) tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL mwr_addr k %0d got %b %h exp 1 %h", k, imem_req, imem_addr, 32'(4 * k)); end
      word = $urandom;
      imem_ready = 1'b1; tick();
      imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = word; tick();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== word) begin errors++; $display("FAIL mwr_instr k %0d got %b %h exp 1 %h", k, instr_valid, instr, word); end
      instr_ready = 1'b1; PCSrc = 1'b0; tick();
      instr_ready = 1'b0;
      exp_retire++;
    end
`ifdef FETCH_RETIRE_CNT_EN
    checks++; if (retire_cnt !== 32'd3) begin errors++; $display("FAIL mwr_retire3 got %0d exp 3", retire_cnt); end
`endif
    exp_pc = 32'hC;
  endtask

  // Randomised memory latency, back-pressure, junk responses and branches.
  // The model tracks only the architectural PC, whether a response is owed,
  // and whether an instruction should be on offer.
  task automatic test_random(input int n, input bit fast);
    int   done = 0, budget = 0, rdy_w = 0, rv_w = 0, stall = 0, last = -1;
    bit   pending = 0, exp_valid = 0, nxt_valid, set_pend;
    logic [31:0] w;
    while (done < n && budget < 3000) begin
      budget++;
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instr_valid, exp_valid); end
      if (exp_valid) begin
        w = memw(exp_pc);
        checks++; if (instr !== w || pc_out !== exp_pc) begin errors++; $display("FAIL rnd_instr cyc %0d got %h @%h exp %h @%h", cyc, instr, pc_out, w, exp_pc); end
        checks++; if ({funct7, rs2, rs1, funct3, rd, Op} !== w) begin errors++; $display("FAIL rnd_fields cyc %0d got %h exp %h", cyc, {funct7, rs2, rs1, funct3, rd, Op}, w); end
      end
      if (pending || exp_valid) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_idle cyc %0d got %b exp 0", cyc, imem_req); end
      end
      if (imem_req === 1'b1) begin
        checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, imem_addr, exp_pc); end
      end
`ifdef FETCH_RETIRE_CNT_EN
      checks++; if (retire_cnt !== 32'(exp_retire)) begin errors++; $display("FAIL rnd_retire cyc %0d got %0d exp %0d", cyc, retire_cnt, exp_retire); end
`endif
      nxt_valid = exp_valid; set_pend = 0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      instr_ready = 1'b0; PCSrc = 1'($urandom); pc_target = $urandom;
      if (pending) begin
        if (rv_w == 0) begin
          imem_rvalid = 1'b1; imem_rdata = memw(exp_pc); pending = 0; nxt_valid = 1;
        end else rv_w--;
      end else if ($urandom_range(3) == 0) begin
        imem_rvalid = 1'b1;
      end
      if (imem_req === 1'b1) begin
        if (rdy_w == 0) begin
          imem_ready = 1'b1; set_pend = 1;
          rv_w  = fast ? 0 : $urandom_range(2);
          rdy_w = fast ? 0 : $urandom_range(3);
        end else rdy_w--;
      end
      if (exp_valid) begin
        if (stall == 0) begin
          instr_ready = 1'b1;
          if (fast && last >= 0) begin
            checks++; if (cyc - last != 3) begin errors++; $display("FAIL rnd_throughput got %0d cycles exp 3", cyc - last); end
          end
          last = cyc;
          exp_pc = PCSrc ? (pc_target & 32'hFFFF_FFFC) : exp_pc + 32'd4;
          exp_retire++; done++; nxt_valid = 0;
          stall = fast ? 0 : $urandom_range(3);
        end else stall--;
      end else begin
        instr_ready = 1'($urandom_range(1));
      end
      if (set_pend) pending = 1;
      exp_valid = nxt_valid;
      tick();
    end
    idle_inputs();
    checks++; if (done != n) begin errors++; $display("FAIL rnd_timeout got %0d consumes exp %0d", done, n); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    tick();
    test_reset();
    test_seq_branch();
    test_stall();
    test_wrap_backpressure();
    test_mid_wait_reset();
    test_random(8, 1'b1);
    test_random(60, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-cycle core. Owns the PC and runs a request/response handshake with instruction memory.
- Holds one fetched instruction and presents it to the control path already split into Op, funct3, funct7 and register fields.
- Consumes the branch decision from the control path (PCSrc plus target) to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  ADDR_W  fetch byte address, always word-aligned
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  instruction word
- instr_valid  output  1  buffered instruction available to core
- instr_ready  input  1  core consumes instruction this cycle
- instr  output  32  full instruction word
- Op  output  7  instr[6:0]
- funct3  output  3  instr[14:12]
- funct7  output  7  instr[31:25]
- rd, rs1, rs2  output  5 each  instr[11:7], instr[19:15], instr[24:20]
- pc_out  output  ADDR_W  PC of the buffered instruction
- PCSrc  input  1  1 = take pc_target, 0 = PC+4; sampled only on consume
- pc_target  input  ADDR_W  branch/jump target

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=FETCH, PC=RESET_PC.
  - instr buffer=32'h0000_0013 (NOP), so Op/funct fields decode as addi.
  - instr_valid=0, imem_req=0 during reset, pc_out=RESET_PC.
- Reset applied mid-operation aborts any outstanding fetch. A response arriving after reset in FETCH state is dropped.
- FSM states:
  - FETCH:
    - imem_req=1, imem_addr=PC.
    - imem_ready=1 -> WAIT.
    - imem_rvalid in FETCH is ignored.
  - WAIT:
    - imem_req=0.
    - imem_rvalid=1 -> capture imem_rdata into buffer, pc_out<=PC, -> ISSUE.
  - ISSUE:
    - instr_valid=1; buffer and all field outputs held stable.
    - instr_ready=1 -> PC <= PCSrc ? {pc_target[ADDR_W-1:2],2'b00} : PC+4, -> FETCH.
    - instr_ready=0 -> stay in ISSUE.
- instr_valid is registered: high only in ISSUE, drops the cycle after consume.
- Minimum latency: req cycle N (ready=1), rvalid at N+1, instr_valid at N+2, next req at N+3. Throughput is 1 instruction per 3 cycles with zero-wait memory.
- imem_req stays high in FETCH until imem_ready; imem_addr stays stable while imem_req=1.
- Field outputs are combinational slices of the registered buffer, so they are glitch-free relative to clk.
- Arithmetic and boundaries:
  - PC+4 is modulo 2^ADDR_W: 32'hFFFF_FFFC -> 32'h0000_0000.
  - pc_target[1:0] is forced to 0; misaligned targets are silently aligned.
  - PCSrc/pc_target are ignored unless instr_valid&instr_ready.
  - instr_ready while instr_valid=0 has no effect.
  - Simultaneous imem_ready and imem_rvalid in FETCH: request accepted, data ignored.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt [31:0].
  - Reset 0; increments by 1 on each instr_valid&instr_ready; wraps 32'hFFFF_FFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ready=1, rvalid next cycle with rdata=32'h00500093 -> imem_addr=0 in FETCH; instr_valid two cycles after req; Op=7'h13, rd=1, funct3=0, pc_out=0.
- Sequential run of 3 instructions with instr_ready=1 -> imem_addr sequence 0,4,8; each instr_valid pulse 1 cycle wide, spaced 3 cycles.
- Branch: at pc_out=8, PCSrc=1, pc_target=32'h0000_0042 -> next imem_addr=32'h40.
- Stall: instr_ready=0 for 5 cycles -> instr_valid held, instr and pc_out unchanged, imem_req=0; consume on cycle 6 -> FETCH at PC+4.
- Wrap and back-pressure: RESET_PC=32'hFFFF_FFFC with imem_ready low 4 cycles -> imem_req/addr held at FFFF_FFFC; after consume, next addr=0.
- Mid-WAIT reset: rst=0 while in WAIT, rvalid arrives in first FETCH cycle -> data dropped, instr_valid stays 0, refetch from RESET_PC; with FETCH_RETIRE_CNT_EN, retire_cnt=0 after reset and =3 after 3 consumes.
